// File: rtl/rv64_pkg.sv
// Shared RV64I decode definitions: opcodes, immediate formats and stage state encoding.
package rv64_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE
  } imm_fmt_e;

  // Encoded as {id_valid, skid_valid}; 2'b01 never occurs.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_TWO   = 2'b11
  } stage_state_e;

endpackage

// File: rtl/rv64_imm_gen.sv
// Combinational immediate generator: classifies the opcode and sign-extends the immediate.
// The format output only exists when RV64_DECODE_ILLEGAL_EN is defined.
module rv64_imm_gen
  import rv64_pkg::*;
#(
  parameter int XLEN = rv64_pkg::XLEN
) (
  input  logic [31:0]     instr,
`ifdef RV64_DECODE_ILLEGAL_EN
  output imm_fmt_e        fmt,
`endif
  output logic [XLEN-1:0] imm
);

  imm_fmt_e fmt_int;

  always_comb begin
    fmt_int = FMT_NONE;
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC:                   fmt_int = FMT_U;
      OPC_JAL:                              fmt_int = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM,
      OPC_OP_IMM_32, OPC_SYSTEM,
      OPC_MISC_MEM:                         fmt_int = FMT_I;
      OPC_STORE:                            fmt_int = FMT_S;
      OPC_BRANCH:                           fmt_int = FMT_B;
      OPC_OP, OPC_OP_32:                    fmt_int = FMT_R;
      default:                              fmt_int = FMT_NONE;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt_int)
      FMT_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      FMT_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      FMT_J: imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

`ifdef RV64_DECODE_ILLEGAL_EN
  assign fmt = fmt_int;
`endif

endmodule

// File: rtl/rv64_decode_stage.sv
// RV64I IF->ID stage with a one-entry skid buffer so if_ready comes straight from a flop.
// Optional illegal-instruction detection is enabled by defining RV64_DECODE_ILLEGAL_EN.
module rv64_decode_stage
  import rv64_pkg::*;
#(
  parameter int XLEN = rv64_pkg::XLEN,
  parameter int ILEN = rv64_pkg::ILEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [ILEN-1:0] if_instr,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7,
  output logic [XLEN-1:0] id_imm,
  output logic            id_is_word,
  output logic            id_illegal
);

  stage_state_e    state_q, state_d;
  logic            load_out, load_skid;
  logic            accept, transfer;
  logic [XLEN-1:0] skid_pc;
  logic [ILEN-1:0] skid_instr;
  logic [XLEN-1:0] dec_pc;
  logic [ILEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_imm;

  assign id_valid = state_q[1];
  assign accept   = if_valid && if_ready;
  assign transfer = id_valid && id_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      if_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      if_ready <= (state_d != ST_TWO);
    end
  end

  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    case (state_q)
      ST_EMPTY: if (accept) begin
        state_d  = ST_ONE;
        load_out = 1'b1;
      end
      ST_ONE: begin
        if (accept && transfer) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_d   = ST_TWO;
          load_skid = 1'b1;
        end else if (transfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: if (transfer) begin
        state_d  = ST_ONE;
        load_out = 1'b1;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d   = ST_EMPTY;
      load_out  = 1'b0;
      load_skid = 1'b0;
    end
  end

  // The skid entry is older than anything on the input, so it always wins the decoder.
  assign dec_pc    = (state_q == ST_TWO) ? skid_pc    : if_pc;
  assign dec_instr = (state_q == ST_TWO) ? skid_instr : if_instr;

`ifdef RV64_DECODE_ILLEGAL_EN
  imm_fmt_e dec_fmt;
  logic     illegal_d;

  rv64_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (dec_instr),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
  );

  always_comb begin
    illegal_d = 1'b0;
    if (dec_instr[1:0] != 2'b11 || dec_fmt == FMT_NONE)
      illegal_d = 1'b1;
    if ((dec_instr[6:0] == OPC_OP || dec_instr[6:0] == OPC_OP_32) &&
        !(dec_instr[31:25] == 7'b0000000 || dec_instr[31:25] == 7'b0100000 ||
          dec_instr[31:25] == 7'b0000001))
      illegal_d = 1'b1;
    if (dec_instr[6:0] == OPC_OP_IMM_32 && dec_instr[13:12] == 2'b01 && dec_instr[25])
      illegal_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         id_illegal <= 1'b0;
    else if (load_out) id_illegal <= illegal_d;
  end
`else
  rv64_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (dec_instr),
    .imm   (dec_imm)
  );

  assign id_illegal = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      skid_pc    <= '0;
      skid_instr <= '0;
    end else if (load_skid) begin
      skid_pc    <= if_pc;
      skid_instr <= if_instr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_pc      <= '0;
      id_opcode  <= '0;
      id_rd      <= '0;
      id_rs1     <= '0;
      id_rs2     <= '0;
      id_funct3  <= '0;
      id_funct7  <= '0;
      id_imm     <= '0;
      id_is_word <= 1'b0;
    end else if (load_out) begin
      id_pc      <= dec_pc;
      id_opcode  <= dec_instr[6:0];
      id_rd      <= dec_instr[11:7];
      id_rs1     <= dec_instr[19:15];
      id_rs2     <= dec_instr[24:20];
      id_funct3  <= dec_instr[14:12];
      id_funct7  <= dec_instr[31:25];
      id_imm     <= dec_imm;
      id_is_word <= (dec_instr[6:0] == OPC_OP_IMM_32) || (dec_instr[6:0] == OPC_OP_32);
    end
  end

endmodule

// File: tb/tb_rv64_decode_stage.sv
// Directed bench for rv64_decode_stage: handshake, skid ordering, immediates, flush, async reset.
module tb_rv64_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [63:0] id_imm;
  logic        id_is_word;
  logic        id_illegal;

  int errors = 0;
  int checks = 0;

  rv64_decode_stage dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_pc      (id_pc),
    .id_opcode  (id_opcode),
    .id_rd      (id_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_funct3  (id_funct3),
    .id_funct7  (id_funct7),
    .id_imm     (id_imm),
    .id_is_word (id_is_word),
    .id_illegal (id_illegal)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one word for a single cycle.
  task automatic send(input logic [63:0] pc, input logic [31:0] instr);
    if_valid = 1'b1;
    if_pc    = pc;
    if_instr = instr;
    tick();
    if_valid = 1'b0;
  endtask

  localparam logic ILL_EN =
`ifdef RV64_DECODE_ILLEGAL_EN
    1'b1;
`else
    1'b0;
`endif

  initial begin
    reset = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
    if_pc = '0; if_instr = '0;
    #12;
    check("rst_id_valid", {63'd0, id_valid}, 64'd0);
    check("rst_if_ready", {63'd0, if_ready}, 64'd1);
    check("rst_id_pc", id_pc, 64'd0);
    check("rst_id_imm", id_imm, 64'd0);
    reset = 1'b0;
    tick();

    // addi x1,x0,10
    send(64'd0, 32'h00A00093);
    check("addi_valid", {63'd0, id_valid}, 64'd1);
    check("addi_rd", {59'd0, id_rd}, 64'd1);
    check("addi_rs1", {59'd0, id_rs1}, 64'd0);
    check("addi_imm", id_imm, 64'd10);
    check("addi_funct3", {61'd0, id_funct3}, 64'd0);
    check("addi_opcode", {57'd0, id_opcode}, 64'h13);
    tick();
    check("drain_valid", {63'd0, id_valid}, 64'd0);

    // Fill the skid buffer while execute stalls, then drain in order.
    id_ready = 1'b0;
    send(64'd0, 32'h00500113);
    check("one_if_ready", {63'd0, if_ready}, 64'd1);
    send(64'd4, 32'h00700193);
    check("two_if_ready", {63'd0, if_ready}, 64'd0);
    check("two_pc", id_pc, 64'd0);
    tick();
    check("stall_pc", id_pc, 64'd0);
    check("stall_rd", {59'd0, id_rd}, 64'd2);
    check("stall_imm", id_imm, 64'd5);
    id_ready = 1'b1;
    tick();
    check("skid_valid", {63'd0, id_valid}, 64'd1);
    check("skid_pc", id_pc, 64'd4);
    check("skid_rd", {59'd0, id_rd}, 64'd3);
    check("skid_imm", id_imm, 64'd7);
    check("skid_if_ready", {63'd0, if_ready}, 64'd1);
    tick();
    check("skid_drain", {63'd0, id_valid}, 64'd0);

    // Immediate formats, back-to-back with execute always ready.
    send(64'h100, 32'hFE000EE3);
    check("beq_imm", id_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    send(64'h104, 32'h800000B7);
    check("lui_imm", id_imm, 64'hFFFF_FFFF_8000_0000);
    check("lui_pc", id_pc, 64'h104);
    send(64'h108, 32'h001000EF);
    check("jal_imm", id_imm, 64'd2048);
    send(64'h10C, 32'hFE20AC23);
    check("sw_imm", id_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    check("sw_rs2", {59'd0, id_rs2}, 64'd2);
    send(64'h110, 32'h002081B3);
    check("add_imm", id_imm, 64'd0);
    check("add_is_word", {63'd0, id_is_word}, 64'd0);
    tick();

    // Flush in TWO with a concurrent offer.
    id_ready = 1'b0;
    send(64'h200, 32'h00100093);
    send(64'h204, 32'h00200093);
    check("pre_flush_ready", {63'd0, if_ready}, 64'd0);
    flush = 1'b1; if_valid = 1'b1; if_pc = 64'h208; if_instr = 32'h00300093;
    tick();
    flush = 1'b0; if_valid = 1'b0;
    check("flush_valid", {63'd0, id_valid}, 64'd0);
    check("flush_if_ready", {63'd0, if_ready}, 64'd1);
    id_ready = 1'b1;
    tick();
    check("flush_no_emit", {63'd0, id_valid}, 64'd0);
    flush = 1'b1;
    send(64'h20C, 32'h00400093);
    flush = 1'b0;
    check("flush_accept_drop", {63'd0, id_valid}, 64'd0);

    // Illegal detection and W-suffix flag.
    send(64'h300, 32'h0000_0000);
    check("zero_illegal", {63'd0, id_illegal}, {63'd0, ILL_EN});
    send(64'h304, 32'h0020_80BB);
    check("addw_is_word", {63'd0, id_is_word}, 64'd1);
    check("addw_illegal", {63'd0, id_illegal}, 64'd0);
    tick();

    // Async reset while holding two entries.
    id_ready = 1'b0;
    send(64'h400, 32'h00100093);
    send(64'h404, 32'h00200093);
    check("pre_rst_valid", {63'd0, id_valid}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", {63'd0, id_valid}, 64'd0);
    check("async_rst_ready", {63'd0, if_ready}, 64'd1);
    @(posedge clock);
    #1 reset = 1'b0;
    id_ready = 1'b1;
    tick();
    check("post_rst_valid", {63'd0, id_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
